// File: rtl/ma_mem_ctrl.sv
// RV32I memory-access-stage controller: req/ack sequencing, alignment checks, strobes and load formatting.
// Define MA_PERF_CNT_EN to build the stall/access performance counters.
module ma_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ma_valid,
    input  logic        Load_in,
    input  logic        MemRW_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ALU_Result_in,
    input  logic [31:0] DataB_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        wb_kill,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_access_cnt
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 is_load_q;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;

    logic                 acc;
    logic                 is_store;
    logic                 bad;
    logic                 start;
    logic [1:0]           off;
    logic [SW-1:0]        wstrb_c;
    logic [XLEN-1:0]      wdata_c;
    logic [XLEN-1:0]      fmt_c;
    logic                 timeout_hit;

    assign off         = ALU_Result_in[1:0];
    assign is_store    = MemRW_in;
    assign acc         = ma_valid & (Load_in | MemRW_in);
    assign start       = (state == IDLE) & acc & ~bad;
    assign timeout_hit = (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    // Alignment and encoding legality; a store never takes the unsigned encodings.
    always_comb begin
        bad = 1'b0;
        if (funct3_in[1:0] == 2'b01 && off[0]) bad = 1'b1;
        if (funct3_in[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;
        if (funct3_in == 3'b011 || funct3_in[2:1] == 2'b11) bad = 1'b1;
        if (is_store && funct3_in[2]) bad = 1'b1;
    end

    // Byte-lane strobes and store-data replication.
    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = DataB_in;
        if (is_store) begin
            case (funct3_in[1:0])
                2'b00: begin
                    wstrb_c = 4'(4'b0001 << off);
                    wdata_c = {4{DataB_in[7:0]}};
                end
                2'b01: begin
                    wstrb_c = 4'(4'b0011 << off);
                    wdata_c = {2{DataB_in[15:0]}};
                end
                default: begin
                    wstrb_c = 4'b1111;
                    wdata_c = DataB_in;
                end
            endcase
        end
    end

    // Lane select and extension of the returned word.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (off_q)
            2'd0:    b = mem_rdata[7:0];
            2'd1:    b = mem_rdata[15:8];
            2'd2:    b = mem_rdata[23:16];
            default: b = mem_rdata[31:24];
        endcase
        h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  fmt_c = {{24{b[7]}}, b};
            3'b100:  fmt_c = {24'd0, b};
            3'b001:  fmt_c = {{16{h[15]}}, h};
            3'b101:  fmt_c = {16'd0, h};
            default: fmt_c = mem_rdata;
        endcase
    end

    // Reset forces stall low at once, even while an access is being presented.
    assign stall = reset_n & ((state == ACCESS) | start);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            to_cnt       <= '0;
            is_load_q    <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            wb_kill      <= 1'b0;
        end else begin
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            wb_kill      <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc && bad) begin
                        misalign_err <= 1'b1;
                        wb_kill      <= 1'b1;
                    end else if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {ALU_Result_in[31:2], 2'b00};
                        mem_wdata <= wdata_c;
                        mem_wstrb <= wstrb_c;
                        is_load_q <= ~is_store;
                        f3_q      <= funct3_in;
                        off_q     <= off;
                        to_cnt    <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    to_cnt <= to_cnt + TIMEOUT_W'(1);
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_load_q) begin
                            load_data  <= fmt_c;
                            load_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        load_data <= '0;
                        bus_err   <= 1'b1;
                        wb_kill   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MA_PERF_CNT_EN
    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt  <= '0;
            perf_access_cnt <= '0;
        end else begin
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (start) perf_access_cnt <= perf_access_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt  = '0;
    assign perf_access_cnt = '0;
`endif

endmodule

// File: tb/tb_ma_mem_ctrl.sv
// Scoreboard bench for ma_mem_ctrl: expected requests/responses are queued by the stimulus and
// checked by independent monitors whenever the DUT presents a request or a response pulse.
module tb_ma_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ma_valid, Load_in, MemRW_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALU_Result_in, DataB_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misalign_err, bus_err, wb_kill;
    logic [31:0] perf_stall_cnt, perf_access_cnt;

    always #5 clk = ~clk;

    ma_mem_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .ma_valid(ma_valid), .Load_in(Load_in),
        .MemRW_in(MemRW_in), .funct3_in(funct3_in), .ALU_Result_in(ALU_Result_in),
        .DataB_in(DataB_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misalign_err(misalign_err), .bus_err(bus_err),
        .wb_kill(wb_kill), .perf_stall_cnt(perf_stall_cnt), .perf_access_cnt(perf_access_cnt)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    // flags = {load_valid, misalign_err, bus_err, wb_kill}
    typedef struct packed {
        logic [3:0]  flags;
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: DUT presented an output with no expectation queued", name);
    endtask

    // Request monitor: check fields on the first request cycle, stability afterwards.
    logic req_prev = 1'b0;
    req_t cur_req;
    always @(negedge clk) begin
        if (mem_req && !req_prev) begin
            if (req_q.size() == 0) flag_unexpected("req");
            else begin
                cur_req = req_q.pop_front();
                chk("req_addr", mem_addr, cur_req.addr);
                chk("req_we", {31'd0, mem_we}, {31'd0, cur_req.we});
                chk("req_wstrb", {28'd0, mem_wstrb}, {28'd0, cur_req.wstrb});
                if (cur_req.we) chk("req_wdata", mem_wdata, cur_req.wdata);
            end
        end else if (mem_req) begin
            chk("req_hold_addr", mem_addr, cur_req.addr);
            chk("req_hold_wstrb", {28'd0, mem_wstrb}, {28'd0, cur_req.wstrb});
        end
        req_prev = mem_req;
    end

    // Response monitor: any pulse pops one expected response.
    always @(negedge clk) begin
        rsp_t r;
        if (load_valid || misalign_err || bus_err || wb_kill) begin
            if (rsp_q.size() == 0) flag_unexpected("rsp");
            else begin
                r = rsp_q.pop_front();
                chk("rsp_flags", {28'd0, load_valid, misalign_err, bus_err, wb_kill},
                    {28'd0, r.flags});
                if (r.chk_data) chk("rsp_data", load_data, r.data);
            end
        end
    end

    task automatic exp_req(input logic [31:0] a, input logic we, input logic [3:0] s,
                           input logic [31:0] d);
        req_t q;
        q.addr = a; q.we = we; q.wstrb = s; q.wdata = d;
        req_q.push_back(q);
    endtask

    task automatic exp_rsp(input logic [3:0] f, input logic c, input logic [31:0] d);
        rsp_t r;
        r.flags = f; r.chk_data = c; r.data = d;
        rsp_q.push_back(r);
    endtask

    // Present one instruction for a single cycle, act as memory for 10 cycles (ack_at=0: never ack).
    task automatic run_acc(input string name, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] db, input int ack_at,
                           input logic [31:0] rdata, input int exp_stall, input int exp_reqc);
        int stall_n = 0;
        int req_n   = 0;
        @(posedge clk); #1;
        ma_valid = 1'b1; Load_in = ld; MemRW_in = st; funct3_in = f3;
        ALU_Result_in = addr; DataB_in = db;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (mem_req) begin
                req_n++;
                mem_ack   = (ack_at == req_n);
                mem_rdata = mem_ack ? rdata : 32'h5A5A_5A5A;
            end else begin
                mem_ack = 1'b0;
            end
            @(posedge clk); #1;
            ma_valid = 1'b0;
        end
        mem_ack = 1'b0;
        chk({name, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        chk({name, "_req_cycles"}, 32'(req_n), 32'(exp_reqc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ma_valid = 1'b0; Load_in = 1'b0; MemRW_in = 1'b0;
        funct3_in = 3'd0; ALU_Result_in = '0; DataB_in = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_pulses", {28'd0, load_valid, misalign_err, bus_err, wb_kill}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_perf", perf_stall_cnt | perf_access_cnt, 32'd0);
        reset_n = 1'b1;

        // LW, ack on 2nd ACCESS cycle
        exp_req(32'h100, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b1000, 1'b1, 32'hDEAD_BEEF);
        run_acc("lw", 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 3, 2);
`ifdef MA_PERF_CNT_EN
        chk("perf_access", perf_access_cnt, 32'd1);
        chk("perf_stall", perf_stall_cnt, 32'd3);
`else
        chk("perf_access", perf_access_cnt, 32'd0);
        chk("perf_stall", perf_stall_cnt, 32'd0);
`endif

        exp_req(32'h100, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b1000, 1'b1, 32'hFFFF_FF80);
        run_acc("lb", 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_FFFF, 2, 1);

        exp_req(32'h100, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b1000, 1'b1, 32'h0000_0080);
        run_acc("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_FFFF, 2, 1);

        exp_req(32'h100, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b1000, 1'b1, 32'hFFFF_8001);
        run_acc("lh", 1, 0, 3'b001, 32'h102, 32'h0, 3, 32'h8001_1234, 4, 3);

        exp_req(32'h100, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b1000, 1'b1, 32'h0000_8001);
        run_acc("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h1234_8001, 2, 1);

        exp_req(32'h100, 1'b1, 4'b1100, 32'hABCD_ABCD);
        run_acc("sh", 0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 1, 32'h0, 2, 1);

        exp_req(32'h100, 1'b1, 4'b0010, 32'hEFEF_EFEF);
        run_acc("sb", 0, 1, 3'b000, 32'h101, 32'h0000_00EF, 2, 32'h0, 3, 2);

        // Load and store both set: treated as a store
        exp_req(32'h10C, 1'b1, 4'b1111, 32'hCAFE_F00D);
        run_acc("sw_both", 1, 1, 3'b010, 32'h10C, 32'hCAFE_F00D, 1, 32'h1111_1111, 2, 1);

        exp_rsp(4'b0101, 1'b0, 32'h0);
        run_acc("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 0, 0);

        exp_rsp(4'b0101, 1'b0, 32'h0);
        run_acc("lh_mis", 1, 0, 3'b001, 32'h103, 32'h0, 1, 32'h0, 0, 0);

        exp_rsp(4'b0101, 1'b0, 32'h0);
        run_acc("st_f3_100", 0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0, 0, 0);

        exp_rsp(4'b0101, 1'b0, 32'h0);
        run_acc("ld_f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 0, 0);

        // Timeout: TIMEOUT_CYCLES=4, no ack
        exp_req(32'h104, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b0011, 1'b1, 32'h0);
        run_acc("timeout", 1, 0, 3'b010, 32'h104, 32'h0, 0, 32'h0, 5, 4);

        exp_req(32'h108, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b1000, 1'b1, 32'h1122_3344);
        run_acc("lw_after_to", 1, 0, 3'b010, 32'h108, 32'h0, 1, 32'h1122_3344, 2, 1);

        // Stray ack while idle must be ignored
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ack_stall", {31'd0, stall}, 32'd0);

        // Reset in the middle of ACCESS
        exp_req(32'h200, 1'b0, 4'b1111, 32'h0);
        @(posedge clk); #1;
        ma_valid = 1'b1; Load_in = 1'b1; MemRW_in = 1'b0; funct3_in = 3'b010;
        ALU_Result_in = 32'h200;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_high", {31'd0, mem_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_perf", perf_stall_cnt | perf_access_cnt, 32'd0);
        @(posedge clk); #1;
        ma_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);

        exp_req(32'h300, 1'b0, 4'b1111, 32'h0);
        exp_rsp(4'b1000, 1'b1, 32'h0000_00A5);
        run_acc("lbu_recover", 1, 0, 3'b100, 32'h300, 32'h0, 1, 32'h1234_56A5, 2, 1);

        repeat (2) @(negedge clk);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
